audio_init_sequencer: RTL and testbench
=======================================

AUDIO_INIT_SEQUENCER -- requirements
Module: audio_init_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8, number of audio channels addressable (>=2).
REQ-002 SHALL have parameter NUM_STEPS, default 8, number of configuration writes in the table (>=1).
REQ-003 SHALL have parameter POR_CYCLES, default 588, downstream reset hold length in clocks (>=1).
REQ-004 SHALL have parameter STEP_TABLE, default all-zero, packed NUM_STEPS x 44 bits; step i at bits [44*i+43 : 44*i] = {channel[7:0], register[3:0], data[31:0]}.
REQ-005 clk_25mhz  input  1  system clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 restart  input  1  single-cycle request to replay the table without POR.
REQ-008 sys_rst  output  1  active-high reset for the audio system and memory.
REQ-009 cfg_valid  output  1  configuration write offered.
REQ-010 cfg_ready  input  1  audio system accepts the write.
REQ-011 channelSelect  output  $clog2(NUM_CHANNELS)  target channel.
REQ-012 registerSelect  output  4  channel setting code.
REQ-013 registerData  output  32  setting value.
REQ-014 busy  output  1  high in POR_WAIT or ISSUE.
REQ-015 done  output  1  high in DONE.
REQ-016 bad_step  output  1  sticky flag: at least one step skipped as invalid.

Function
REQ-017 States: POR_WAIT, ISSUE, DONE; reset enters POR_WAIT.
REQ-018 POR_WAIT: sys_rst=1; counter runs 0..POR_CYCLES-1; on count POR_CYCLES-1, next cycle sys_rst=0 and state ISSUE at step 0.
REQ-019 ISSUE: cfg_valid=1 with channelSelect/registerSelect/registerData driven from the current step; outputs SHALL remain stable until cfg_valid&&cfg_ready.
REQ-020 Transfer occurs on the cycle where cfg_valid&&cfg_ready; step index increments next cycle; after the transfer of step NUM_STEPS-1, state DONE.
REQ-021 Step whose channel >= NUM_CHANNELS or register==0 (IDLE) SHALL be skipped in one cycle with cfg_valid=0, and set bad_step only for channel out of range.
REQ-022 Valid steps SHALL be issued strictly in table order, one transfer per step, no duplicates.
REQ-023 channelSelect SHALL be the low $clog2(NUM_CHANNELS) bits of the step channel field.
REQ-024 DONE: cfg_valid=0, done=1; restart=1 moves to ISSUE at step 0 next cycle, sys_rst stays 0, bad_step cleared.
REQ-025 restart while in POR_WAIT or ISSUE SHALL be ignored.
REQ-026 cfg_ready while cfg_valid=0 SHALL have no effect.
REQ-027 Step index wraps never; width $clog2(NUM_STEPS+1).

Reset
REQ-028 rst=0 at any clock edge, including mid-transfer, SHALL abort and give next cycle: state POR_WAIT, counter 0, step 0, sys_rst=1, cfg_valid=0, busy=1, done=0, bad_step=0, channelSelect=0, registerSelect=0, registerData=0.
REQ-029 While rst=0, outputs SHALL hold the reset values of REQ-028.

Structure
REQ-030 Package audio_cfg_pkg SHALL hold the ChannelSettings enum (IDLE=0 … SET_ISRIGHT=11), step field widths, and the sequencer state enum.
REQ-031 POR counter SHALL be sub-module por_counter (parameter CYCLES, output active-high hold).

Verification
REQ-032 POR_CYCLES=4, release rst -> sys_rst high exactly 4 cycles, cfg_valid rises on the first cycle sys_rst=0.
REQ-033 3-step table {3,SET_SAMPLECOUNT,239616},{3,SET_LOOPEND,239615},{3,SET_ISPLAYING,1}, cfg_ready=1 -> three consecutive transfers with those values, then done=1.
REQ-034 cfg_ready held 0 for 5 cycles on step 1 -> outputs unchanged for 5 cycles, transfer on cycle 6, no step lost.
REQ-035 NUM_CHANNELS=4, step channel=6 -> step skipped, cfg_valid=0 that cycle, bad_step=1, remaining steps issued.
REQ-036 rst=0 during step 2 transfer -> next cycle REQ-028 values; after release, full POR then replay from step 0.
REQ-037 restart pulse in DONE -> replay from step 0 without sys_rst; restart pulse in ISSUE -> ignored.

Source files
------------

// File: rtl/audio_cfg_pkg.sv
// Shared definitions for the audio initialisation sequencer.
//   - channel_settings_e : register codes understood by an audio channel
//   - step field widths and the packed table entry layout
//   - seq_state_e        : sequencer FSM encoding (also used by the debug port)
package audio_cfg_pkg;

  typedef enum logic [3:0] {
    IDLE            = 4'd0,
    SET_ISPLAYING   = 4'd1,
    SET_ISLOOPING   = 4'd2,
    SET_LOOPSTART   = 4'd3,
    SET_LOOPEND     = 4'd4,
    SET_SAMPLECOUNT = 4'd5,
    SET_STARTADDR   = 4'd6,
    SET_VOLUME      = 4'd7,
    SET_PAN         = 4'd8,
    SET_RATE        = 4'd9,
    SET_ISLEFT      = 4'd10,
    SET_ISRIGHT     = 4'd11
  } channel_settings_e;

  localparam int CH_W   = 8;
  localparam int REG_W  = 4;
  localparam int DATA_W = 32;
  localparam int STEP_W = CH_W + REG_W + DATA_W;

  // One table entry: {channel, register, data}, channel in the top bits.
  typedef struct packed {
    logic [CH_W-1:0]   channel;
    logic [REG_W-1:0]  setting;
    logic [DATA_W-1:0] data;
  } cfg_step_t;

  typedef enum logic [1:0] {
    SEQ_POR_WAIT = 2'd0,
    SEQ_ISSUE    = 2'd1,
    SEQ_DONE     = 2'd2
  } seq_state_e;

endpackage

// File: rtl/por_counter.sv
// Power-on reset hold counter.
// After reset release, hold_o stays high for exactly CYCLES clocks
// (counter 0..CYCLES-1), then drops and stays low until the next reset.
//   clk_25mhz : clock
//   rst       : synchronous active-low reset (restarts the hold)
//   hold_o    : active-high downstream reset hold
//   last_o    : high on the final hold cycle (count == CYCLES-1)
module por_counter #(
  parameter int CYCLES = 588
) (
  input  logic clk_25mhz,
  input  logic rst,
  output logic hold_o,
  output logic last_o
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q, hold_d;

  assign hold_o = hold_q;
  assign last_o = hold_q && (cnt_q == CW'(CYCLES - 1));

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    if (hold_q) begin
      if (last_o) begin
        hold_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst) begin
      cnt_q  <= '0;
      hold_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/audio_init_sequencer.sv
// Audio system initialisation sequencer.
// Holds the audio system in reset for POR_CYCLES clocks, then replays a
// constant table of configuration writes over a valid/ready port, then
// idles in DONE until a restart request replays the table (without POR).
//
// Handshake: cfg_valid is raised with channelSelect/registerSelect/
// registerData for the current step; the bundle is held stable until the
// cycle where cfg_valid && cfg_ready (the transfer). cfg_ready is ignored
// whenever cfg_valid is low. A step is invalid (channel out of range or
// register IDLE) and is skipped in one cycle with cfg_valid low.
//
// Ports:
//   clk_25mhz, rst (sync, active-low), restart (pulse, honoured in DONE)
//   sys_rst        : active-high reset for audio system and memory
//   cfg_valid/cfg_ready, channelSelect, registerSelect, registerData
//   busy (POR_WAIT or ISSUE), done (DONE), bad_step (sticky skip flag)
//   dbg_state      : current FSM state (seq_state_e encoding)
module audio_init_sequencer
  import audio_cfg_pkg::*;
#(
  parameter int                         NUM_CHANNELS = 8,
  parameter int                         NUM_STEPS    = 8,
  parameter int                         POR_CYCLES   = 588,
  parameter logic [NUM_STEPS*STEP_W-1:0] STEP_TABLE   = '0
) (
  input  logic                            clk_25mhz,
  input  logic                            rst,
  input  logic                            restart,
  output logic                            sys_rst,
  output logic                            cfg_valid,
  input  logic                            cfg_ready,
  output logic [$clog2(NUM_CHANNELS)-1:0] channelSelect,
  output logic [3:0]                      registerSelect,
  output logic [31:0]                     registerData,
  output logic                            busy,
  output logic                            done,
  output logic                            bad_step,
  output logic [1:0]                      dbg_state
);

  localparam int SW  = $clog2(NUM_STEPS + 1);
  localparam int CSW = $clog2(NUM_CHANNELS);

  localparam logic [1:0] S_POR_WAIT = SEQ_POR_WAIT;
  localparam logic [1:0] S_ISSUE    = SEQ_ISSUE;
  localparam logic [1:0] S_DONE     = SEQ_DONE;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic          bad_q, bad_d;

  logic          por_hold;
  logic          por_last;
  cfg_step_t     cur_step;
  logic          ch_ok;
  logic          step_ok;
  logic          last_step;

  por_counter #(
    .CYCLES(POR_CYCLES)
  ) u_por (
    .clk_25mhz(clk_25mhz),
    .rst      (rst),
    .hold_o   (por_hold),
    .last_o   (por_last)
  );

  // Table lookup as an explicit mux so step_q == NUM_STEPS (DONE) never
  // selects outside the table.
  always_comb begin
    cur_step = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (step_q == SW'(i)) begin
        cur_step = STEP_TABLE[STEP_W*i +: STEP_W];
      end
    end
  end

  assign ch_ok     = (int'(cur_step.channel) < NUM_CHANNELS);
  assign step_ok   = ch_ok && (cur_step.setting != IDLE);
  assign last_step = (step_q == SW'(NUM_STEPS - 1));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    bad_d   = bad_q;
    case (state_q)
      S_POR_WAIT: begin
        if (por_last) begin
          state_d = S_ISSUE;
          step_d  = '0;
        end
      end
      S_ISSUE: begin
        // Advance on a transfer, or unconditionally when skipping.
        if (!step_ok || cfg_ready) begin
          step_d = step_q + SW'(1);
          if (!ch_ok) begin
            bad_d = 1'b1;
          end
          if (last_step) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (restart) begin
          state_d = S_ISSUE;
          step_d  = '0;
          bad_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_POR_WAIT;
        step_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst) begin
      state_q <= S_POR_WAIT;
      step_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      bad_q   <= bad_d;
    end
  end

  // Payload is forced to zero whenever nothing is offered.
  assign cfg_valid      = (state_q == S_ISSUE) && step_ok;
  assign channelSelect  = cfg_valid ? cur_step.channel[CSW-1:0] : '0;
  assign registerSelect = cfg_valid ? cur_step.setting : '0;
  assign registerData   = cfg_valid ? cur_step.data : '0;

  assign sys_rst   = por_hold;
  assign busy      = (state_q == S_POR_WAIT) || (state_q == S_ISSUE);
  assign done      = (state_q == S_DONE);
  assign bad_step  = bad_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_audio_init_sequencer.sv
module tb_audio_init_sequencer;

  localparam int NUM_CHANNELS = 4;
  localparam int NUM_STEPS    = 6;
  localparam int POR_CYCLES   = 4;

  // Table: three channel-3 writes, an out-of-range channel, an IDLE
  // register, then one more valid write.
  localparam logic [43:0] S0 = {8'd3, 4'd5, 32'd239616};   // SET_SAMPLECOUNT
  localparam logic [43:0] S1 = {8'd3, 4'd4, 32'd239615};   // SET_LOOPEND
  localparam logic [43:0] S2 = {8'd3, 4'd1, 32'd1};        // SET_ISPLAYING
  localparam logic [43:0] S3 = {8'd6, 4'd7, 32'h0000_0055}; // channel 6 >= 4
  localparam logic [43:0] S4 = {8'd1, 4'd0, 32'h0000_1234}; // IDLE
  localparam logic [43:0] S5 = {8'd2, 4'd8, 32'hA5A5_0001}; // SET_PAN
  localparam logic [NUM_STEPS*44-1:0] TABLE = {S5, S4, S3, S2, S1, S0};

  // Expected bus {channelSelect[1:0], registerSelect, registerData}
  localparam logic [37:0] EXP0 = {2'd3, 4'd5, 32'd239616};
  localparam logic [37:0] EXP1 = {2'd3, 4'd4, 32'd239615};
  localparam logic [37:0] EXP2 = {2'd3, 4'd1, 32'd1};
  localparam logic [37:0] EXP5 = {2'd2, 4'd8, 32'hA5A5_0001};

  // flags = {sys_rst, cfg_valid, busy, done, bad_step}
  localparam logic [4:0] F_RESET = 5'b10100;
  localparam logic [4:0] F_OFFER = 5'b01100;
  localparam logic [4:0] F_SKIP  = 5'b00100;
  localparam logic [4:0] F_SKIPB = 5'b00101;
  localparam logic [4:0] F_OFFRB = 5'b01101;
  localparam logic [4:0] F_DONEB = 5'b00011;

  // ---------------- clock / reset block ----------------
  logic clk_25mhz = 1'b0;
  logic rst       = 1'b0;
  logic restart   = 1'b0;
  logic cfg_ready = 1'b0;

  always #20 clk_25mhz = ~clk_25mhz;

  logic        sys_rst, cfg_valid, busy, done, bad_step;
  logic [1:0]  channelSelect;
  logic [3:0]  registerSelect;
  logic [31:0] registerData;
  logic [1:0]  dbg_state;

  audio_init_sequencer #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .NUM_STEPS   (NUM_STEPS),
    .POR_CYCLES  (POR_CYCLES),
    .STEP_TABLE  (TABLE)
  ) dut (
    .clk_25mhz     (clk_25mhz),
    .rst           (rst),
    .restart       (restart),
    .sys_rst       (sys_rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .channelSelect (channelSelect),
    .registerSelect(registerSelect),
    .registerData  (registerData),
    .busy          (busy),
    .done          (done),
    .bad_step      (bad_step),
    .dbg_state     (dbg_state)
  );

  logic [37:0] bus;
  logic [4:0]  flags;
  assign bus   = {channelSelect, registerSelect, registerData};
  assign flags = {sys_rst, cfg_valid, busy, done, bad_step};

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard ----------------
  logic [37:0] exp_q[$];
  logic [37:0] obs_q[$];

  always @(posedge clk_25mhz) begin
    if (rst && cfg_valid && cfg_ready) obs_q.push_back(bus);
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b0;
    cfg_ready = 1'b1;
    repeat (3) @(negedge clk_25mhz);
    n_checks++;
    if (flags !== F_RESET) begin
      n_errors++; $display("FAIL reset_flags: got %b want %b", flags, F_RESET);
    end
    n_checks++;
    if (bus !== 38'd0) begin
      n_errors++; $display("FAIL reset_bus: got %h want 0", bus);
    end
    n_checks++;
    if (dbg_state !== 2'd0) begin
      n_errors++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
  endtask

  // Releases reset (cfg_ready high during POR must have no effect) and
  // measures how many sampled cycles sys_rst stays high.
  task automatic test_por(input string tag);
    int cnt;
    rst = 1'b1;
    cfg_ready = 1'b1;
    cnt = 0;
    while (sys_rst === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk_25mhz);
    end
    cfg_ready = 1'b0;
    n_checks++;
    if (cnt != POR_CYCLES) begin
      n_errors++; $display("FAIL %s_por_len: got %0d want %0d", tag, cnt, POR_CYCLES);
    end
    n_checks++;
    if (flags !== F_OFFER) begin
      n_errors++; $display("FAIL %s_first_issue_flags: got %b want %b", tag, flags, F_OFFER);
    end
    n_checks++;
    if (bus !== EXP0) begin
      n_errors++; $display("FAIL %s_first_issue_bus: got %h want %h", tag, bus, EXP0);
    end
  endtask

  task automatic test_stall_and_skip();
    cfg_ready = 1'b1;
    @(negedge clk_25mhz);
    n_checks++;
    if (bus !== EXP1) begin
      n_errors++; $display("FAIL step1_bus: got %h want %h", bus, EXP1);
    end
    cfg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_25mhz);
      n_checks++;
      if (bus !== EXP1 || flags !== F_OFFER) begin
        n_errors++;
        $display("FAIL stall_cyc%0d: got bus %h flags %b want bus %h flags %b",
                 i, bus, flags, EXP1, F_OFFER);
      end
    end
    cfg_ready = 1'b1;
    @(negedge clk_25mhz);
    n_checks++;
    if (bus !== EXP2) begin
      n_errors++; $display("FAIL step2_bus: got %h want %h", bus, EXP2);
    end
    @(negedge clk_25mhz);
    n_checks++;
    if (flags !== F_SKIP || bus !== 38'd0) begin
      n_errors++; $display("FAIL skip_badch: got flags %b bus %h want %b 0", flags, bus, F_SKIP);
    end
    @(negedge clk_25mhz);
    n_checks++;
    if (flags !== F_SKIPB) begin
      n_errors++; $display("FAIL skip_idle: got flags %b want %b", flags, F_SKIPB);
    end
    @(negedge clk_25mhz);
    n_checks++;
    if (flags !== F_OFFRB || bus !== EXP5) begin
      n_errors++; $display("FAIL step5: got flags %b bus %h want %b %h", flags, bus, F_OFFRB, EXP5);
    end
    @(negedge clk_25mhz);
    n_checks++;
    if (flags !== F_DONEB || dbg_state !== 2'd2) begin
      n_errors++; $display("FAIL done_flags: got %b st %0d want %b st 2", flags, dbg_state, F_DONEB);
    end
    repeat (3) @(negedge clk_25mhz);
    n_checks++;
    if (flags !== F_DONEB) begin
      n_errors++; $display("FAIL done_hold: got %b want %b", flags, F_DONEB);
    end
    exp_q = '{EXP0, EXP1, EXP2, EXP5};
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL run1_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL run1_xfer%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_q.delete();
    cfg_ready = 1'b1;
    restart = 1'b1;
    @(negedge clk_25mhz);
    restart = 1'b0;
    n_checks++;
    if (flags !== F_OFFER || bus !== EXP0) begin
      n_errors++; $display("FAIL replay_start: got flags %b bus %h want %b %h", flags, bus, F_OFFER, EXP0);
    end
    @(negedge clk_25mhz);
    n_checks++;
    if (bus !== EXP1) begin
      n_errors++; $display("FAIL replay_step1: got %h want %h", bus, EXP1);
    end
    restart = 1'b1;   // must be ignored while issuing
    @(negedge clk_25mhz);
    restart = 1'b0;
    n_checks++;
    if (bus !== EXP2 || dbg_state !== 2'd1) begin
      n_errors++; $display("FAIL restart_in_issue: got bus %h st %0d want %h st 1", bus, dbg_state, EXP2);
    end
    repeat (4) @(negedge clk_25mhz);
    n_checks++;
    if (flags !== F_DONEB) begin
      n_errors++; $display("FAIL replay_done: got %b want %b", flags, F_DONEB);
    end
    exp_q = '{EXP0, EXP1, EXP2, EXP5};
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL run2_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL run2_xfer%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    int cnt;
    obs_q.delete();
    cfg_ready = 1'b1;
    restart = 1'b1;
    @(negedge clk_25mhz);
    restart = 1'b0;
    repeat (2) @(negedge clk_25mhz);
    n_checks++;
    if (bus !== EXP2) begin
      n_errors++; $display("FAIL mid_pre_step2: got %h want %h", bus, EXP2);
    end
    rst = 1'b0;       // aborts the step-2 transfer at the next edge
    @(negedge clk_25mhz);
    n_checks++;
    if (flags !== F_RESET || bus !== 38'd0 || dbg_state !== 2'd0) begin
      n_errors++; $display("FAIL mid_reset: got flags %b bus %h st %0d want %b 0 0",
                           flags, bus, dbg_state, F_RESET);
    end
    @(negedge clk_25mhz);
    n_checks++;
    if (flags !== F_RESET || bus !== 38'd0) begin
      n_errors++; $display("FAIL mid_reset_hold: got flags %b bus %h want %b 0", flags, bus, F_RESET);
    end
    test_por("rerun");
    cfg_ready = 1'b1;
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk_25mhz);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++; $display("FAIL rerun_done: got %b want 1 within 20 cycles", done);
    end
    exp_q = '{EXP0, EXP1, EXP0, EXP1, EXP2, EXP5};
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL run3_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++; $display("FAIL run3_xfer%0d: got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_por("boot");
    test_stall_and_skip();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
